// File: rtl/conv1_maxpool.sv
// conv1_maxpool: 2x2 / stride-2 max pooling over three signed channels that
// arrive together in raster order. The even row of each window pair is
// reduced to per-column maxima held in a line buffer. The odd row then
// completes each window. A single output register with a valid/ready
// handshake holds each result until downstream consumes it.
//
// state  | meaning
// S_EVEN | current input row is even; pair maxima go into the line buffer
// S_ODD  | current input row is odd; pair maxima complete pooled results
module conv1_maxpool #(
    parameter int IN_WIDTH  = 22,
    parameter int IN_HEIGHT = 22,
    parameter int DATA_BITS = 23,
    parameter int RELU      = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic signed [DATA_BITS-1:0] conv_in_1,
    input  logic signed [DATA_BITS-1:0] conv_in_2,
    input  logic signed [DATA_BITS-1:0] conv_in_3,
    output logic                        maxpool_ready,
    input  logic                        next_ready,
    output logic signed [DATA_BITS-1:0] pool_out_1,
    output logic signed [DATA_BITS-1:0] pool_out_2,
    output logic signed [DATA_BITS-1:0] pool_out_3,
    output logic                        valid_out,
    output logic                        frame_done
);

    localparam int CW = $clog2(IN_WIDTH);
    localparam int RW = $clog2(IN_HEIGHT);
    localparam int HW = IN_WIDTH / 2;
    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

    typedef enum logic {S_EVEN, S_ODD} state_t;

    state_t state, state_next;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-2:0] lb_idx;
    logic          accept;
    logic          col_end;
    logic          load;
    logic          last_result;
    logic          out_last;

    logic signed [DATA_BITS-1:0] sample  [3];
    logic signed [DATA_BITS-1:0] hold    [3];
    logic signed [DATA_BITS-1:0] pairmax [3];
    logic signed [DATA_BITS-1:0] result  [3];
    logic signed [DATA_BITS-1:0] pool_q  [3];
    logic signed [DATA_BITS-1:0] line_buf [3][HW];

    function automatic logic signed [DATA_BITS-1:0] smax(
        input logic signed [DATA_BITS-1:0] a,
        input logic signed [DATA_BITS-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign sample[0] = conv_in_1;
    assign sample[1] = conv_in_2;
    assign sample[2] = conv_in_3;

    // A held result blocks upstream until downstream takes it.
    assign maxpool_ready = !valid_out || next_ready;
    assign accept        = valid_in && maxpool_ready;
    assign col_end       = (col == COL_LAST);
    assign lb_idx        = col[CW-1:1];
    assign load          = accept && col[0] && (state == S_ODD);
    assign last_result   = (row == ROW_LAST) && col_end;
    assign frame_done    = valid_out && next_ready && out_last;

    assign pool_out_1 = pool_q[0];
    assign pool_out_2 = pool_q[1];
    assign pool_out_3 = pool_q[2];

    // State register for the even/odd row phase.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_EVEN;
        else        state <= state_next;
    end

    // Row phase flips after the last column of every row.
    always_comb begin
        state_next = state;
        if (accept && col_end) begin
            case (state)
                S_EVEN:  state_next = S_ODD;
                S_ODD:   state_next = S_EVEN;
                default: state_next = S_EVEN;
            endcase
        end
    end

    // Raster position; advances only on accepted samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Horizontal pair maximum, then vertical maximum against the buffered even row.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            pairmax[c] = smax(hold[c], sample[c]);
            result[c]  = smax(line_buf[c][lb_idx], pairmax[c]);
            if (RELU != 0 && result[c][DATA_BITS-1]) result[c] = '0;
        end
    end

    // Left sample of each column pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) hold[c] <= '0;
        end else if (accept && !col[0]) begin
            for (int c = 0; c < 3; c++) hold[c] <= sample[c];
        end
    end

    // Line buffer is never reset: even rows always fill it before odd rows read it.
    always_ff @(posedge clk) begin
        if (accept && col[0] && state == S_EVEN) begin
            for (int c = 0; c < 3; c++) line_buf[c][lb_idx] <= pairmax[c];
        end
    end

    // Output register: a new result may load in the same cycle the old one drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) pool_q[c] <= '0;
            valid_out <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            for (int c = 0; c < 3; c++) pool_q[c] <= result[c];
            valid_out <= 1'b1;
            out_last  <= last_result;
        end else if (next_ready) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: doc/conv1_maxpool.md
CONV1_MAXPOOL -- requirements
Module: conv1_maxpool

Interface
REQ-001 Parameter IN_WIDTH, default 22, convolution feature-map columns per row; must be even.
REQ-002 Parameter IN_HEIGHT, default 22, convolution feature-map rows per frame; must be even.
REQ-003 Parameter DATA_BITS, default 23, signed sample width per channel.
REQ-004 Parameter RELU, default 1, 1 = clamp pooled result to >= 0, 0 = pass through.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 valid_in  input  1  upstream sample valid, shared by all three channels.
REQ-008 conv_in_1 / conv_in_2 / conv_in_3  input  DATA_BITS each, signed  channel samples in raster order.
REQ-009 maxpool_ready  output  1  ready to upstream; a sample transfers on a cycle where valid_in and maxpool_ready are both 1.
REQ-010 next_ready  input  1  downstream ready.
REQ-011 pool_out_1 / pool_out_2 / pool_out_3  output  DATA_BITS each, signed  pooled results.
REQ-012 valid_out  output  1  pool_out_* hold a valid result.
REQ-013 frame_done  output  1  single-cycle pulse on the cycle the last result of a frame transfers downstream.

Function
REQ-014 Pooling shall be 2x2 with stride 2 per channel: output size (IN_WIDTH/2) x (IN_HEIGHT/2), 11x11 at default.
REQ-015 A col counter shall run 0..IN_WIDTH-1 and a row counter 0..IN_HEIGHT-1; both advance only on an accepted sample; col wraps to 0 and increments row; row wraps to 0 after the last sample of a frame.
REQ-016 The FSM shall have states S_EVEN (row even) and S_ODD (row odd): S_EVEN->S_ODD on acceptance at col=IN_WIDTH-1; S_ODD->S_EVEN on acceptance at col=IN_WIDTH-1.
REQ-017 On an accepted sample with even col, the block shall register the sample per channel as the hold value.
REQ-018 On an accepted sample with odd col, pairmax shall be the signed maximum of the hold value and the sample.
REQ-019 In S_EVEN with odd col, pairmax shall be written to line-buffer entry col/2: IN_WIDTH/2 entries per channel, each DATA_BITS wide.
REQ-020 In S_ODD with odd col, result = signed max(line-buffer[col/2], pairmax); if RELU=1 a negative result shall become 0.
REQ-021 The result shall be loaded into the pool_out_* registers with valid_out=1 on the next clock edge, giving 1-cycle latency from the completing accepted sample.
REQ-022 All comparisons shall be full-width two's-complement; no truncation or saturation.
REQ-023 valid_out shall stay 1 and pool_out_* shall stay stable until a cycle with next_ready=1.
REQ-024 valid_out shall clear on such a cycle unless a new result loads in the same cycle.
REQ-025 maxpool_ready shall equal (!valid_out || next_ready), combinational, so a stalled output blocks upstream with no data loss.
REQ-026 If a result is consumed and a new one completes in the same cycle, the new result shall load and valid_out shall remain 1 (full throughput, one result per 2 accepted odd-row samples).
REQ-027 frame_done shall pulse with the transfer of the result for output (row IN_HEIGHT/2-1, col IN_WIDTH/2-1).
REQ-028 The next frame shall start at row 0, col 0 with no idle cycles required.
REQ-029 Line-buffer contents shall not be reset; every entry is written in S_EVEN before it is read in S_ODD.
REQ-030 Samples presented while maxpool_ready=0 shall be ignored and shall not advance the counters.

Reset
REQ-031 While rst_n=0 at a clock edge, the following shall be cleared: col=0, row=0, state=S_EVEN, hold registers=0, valid_out=0, pool_out_*=0, frame_done=0.
REQ-032 With valid_out=0 after reset, maxpool_ready shall be 1 in the first cycle after reset.
REQ-033 A reset asserted mid-frame shall abandon the partial frame; the first sample after release is treated as row 0, col 0.

Verification
REQ-034 Frame of 484 samples with ch1 = row*22+col, next_ready=1 -> 121 results, result(r,c) = (2r+1)*22+2c+1; first result 23; frame_done pulses once, with the result 483.
REQ-035 Window ch2 = {-5,-9,-3,-7}, RELU=1 -> pool_out_2=0; with RELU=0 -> pool_out_2=-3.
REQ-036 next_ready=0 held 5 cycles while valid_out=1 -> pool_out_* stable, maxpool_ready=0, valid_in samples not consumed; on release the next result is correct with no loss or duplication.
REQ-037 valid_in toggling randomly with next_ready randomly stalled, two back-to-back frames -> outputs match a reference model bit-exactly; 242 results; frame_done pulses exactly twice.
REQ-038 rst_n=0 for 1 cycle after sample 300 -> all outputs 0 the next cycle; a fresh 484-sample frame then yields a correct 121-result frame.
REQ-039 Channel-extremes window {-2^22, 2^22-1, 0, -1} on ch3, RELU=0 -> pool_out_3 = 4194303.
